// File: rtl/uart_rx_deframer.sv
// UART receive deframer: synchronises rx, samples start/data/parity/stop at mid-bit,
// drives the parity checker handshake and publishes one status-qualified word per frame.
module uart_rx_deframer #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 use_parity,
  input  logic                 par_ok,
  output logic                 par_clear,
  output logic                 par_bit,
  output logic                 par_done,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_error,
  output logic                 parity_error,
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT, S_REPORT
  } state_t;

  state_t               state_q, state_d;
  logic                 rx_meta_q, rx_s_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bitcnt_q, bitcnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 use_par_q, use_par_d;
  logic                 stop_bad_q, stop_bad_d;
  logic                 fe_q, fe_d, pe_q, pe_d;
  logic                 clr_q, clr_d, pbit_q, pbit_d, done_q, done_d;
  logic                 valid_q, valid_d, busy_q, busy_d;
  logic                 mid_bit;

  assign mid_bit = (cnt_q == LAST_CNT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      cnt_q      <= '0;
      bitcnt_q   <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      use_par_q  <= 1'b0;
      stop_bad_q <= 1'b0;
      fe_q       <= 1'b0;
      pe_q       <= 1'b0;
      clr_q      <= 1'b0;
      pbit_q     <= 1'b0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_meta_q  <= rx;
      rx_s_q     <= rx_meta_q;
      cnt_q      <= cnt_d;
      bitcnt_q   <= bitcnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      use_par_q  <= use_par_d;
      stop_bad_q <= stop_bad_d;
      fe_q       <= fe_d;
      pe_q       <= pe_d;
      clr_q      <= clr_d;
      pbit_q     <= pbit_d;
      done_q     <= done_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CW'(1);
    bitcnt_d   = bitcnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    use_par_d  = use_par_q;
    stop_bad_d = stop_bad_q;
    fe_d       = fe_q;
    pe_d       = pe_q;
    clr_d      = 1'b0;
    pbit_d     = 1'b0;
    done_d     = 1'b0;
    valid_d    = 1'b0;
    busy_d     = busy_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) begin
          state_d   = S_START;
          bitcnt_d  = '0;
          clr_d     = 1'b1;
          use_par_d = use_parity;
          busy_d    = 1'b1;
        end
      end
      S_START: begin
        if (cnt_q == HALF_CNT) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            state_d = S_DATA;
          end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end
        end
      end
      S_DATA: begin
        if (mid_bit) begin
          cnt_d    = '0;
          shift_d  = {rx_s_q, shift_q[DATA_BITS-1:1]};
          pbit_d   = rx_s_q;
          bitcnt_d = bitcnt_q + BW'(1);
          if (bitcnt_q == LAST_BIT) begin
            state_d = use_par_q ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (mid_bit) begin
          cnt_d   = '0;
          pbit_d  = rx_s_q;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (mid_bit) begin
          cnt_d      = '0;
          stop_bad_d = ~rx_s_q;
          done_d     = 1'b1;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d   = '0;
        state_d = S_REPORT;
      end
      S_REPORT: begin
        // par_ok already reflects the checker's update from the par_done cycle
        cnt_d   = '0;
        data_d  = shift_q;
        fe_d    = stop_bad_q;
        pe_d    = use_par_q & ~par_ok;
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign par_clear    = clr_q;
  assign par_bit      = pbit_q;
  assign par_done     = done_q;
  assign data_out     = data_q;
  assign data_valid   = valid_q;
  assign frame_error  = fe_q;
  assign parity_error = pe_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Randomised frame stimulus for uart_rx_deframer, checked against a frame-level model
// (expected word/status queue) plus a behavioural parity checker answering par_ok.
module tb_uart_rx_deframer;
  localparam int CPB = 16;
  localparam int DB  = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          rx = 1'b1;
  logic          use_parity = 1'b0;
  logic          par_ok;
  logic          par_clear, par_bit, par_done, data_valid, frame_error, parity_error, busy;
  logic [DB-1:0] data_out;

  uart_rx_deframer #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
    .clk(clk), .reset(reset), .rx(rx), .use_parity(use_parity), .par_ok(par_ok),
    .par_clear(par_clear), .par_bit(par_bit), .par_done(par_done), .data_out(data_out),
    .data_valid(data_valid), .frame_error(frame_error), .parity_error(parity_error),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Downstream parity checker: XOR of par_bit pulses; odd_mode selects the sense.
  bit   odd_mode = 1'b0;
  logic chk_acc, chk_upar;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      chk_acc  <= 1'b0;
      chk_upar <= 1'b0;
      par_ok   <= 1'b1;
    end else begin
      if (par_clear) begin
        chk_acc  <= 1'b0;
        chk_upar <= use_parity;
      end else if (par_bit) begin
        chk_acc <= ~chk_acc;
      end
      if (par_done) par_ok <= chk_upar ? (chk_acc == odd_mode) : 1'b1;
    end
  end

  typedef struct {
    logic [DB-1:0] d;
    bit            fe;
    bit            pe;
    int            pb;
  } exp_t;
  exp_t exp_q[$];

  // Output monitor
  int            pb_cnt = 0;
  int            done_cyc = 0;
  bit            done_pend = 1'b0;
  int            valid_cyc = 0;
  logic [DB-1:0] last_d = '0;
  bit            last_fe = 1'b0, last_pe = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      pb_cnt = 0; done_pend = 1'b0; last_d = '0; last_fe = 1'b0; last_pe = 1'b0;
    end else begin
      check("bit_done_overlap", 32'(par_bit & par_done), 0);
      if (par_clear) pb_cnt = 0;
      if (par_bit) pb_cnt++;
      if (par_done) begin done_cyc = cyc; done_pend = 1'b1; end
      if (data_valid) begin
        valid_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("spurious_valid", 32'(data_valid), 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("data_out", 32'(data_out), 32'(e.d));
          check("frame_error", 32'(frame_error), 32'(e.fe));
          check("parity_error", 32'(parity_error), 32'(e.pe));
          check("par_bit_count", pb_cnt, e.pb);
          check("done_seen", 32'(done_pend), 1);
          check("done_to_valid", cyc - done_cyc, 2);
          last_d = e.d; last_fe = e.fe; last_pe = e.pe;
        end
        done_pend = 1'b0;
      end else begin
        check("outputs_hold", {22'd0, data_out, frame_error, parity_error},
              {22'd0, last_d, last_fe, last_pe});
      end
    end
  end

  int start_cyc = 0;

  task automatic bit_out(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input bit up, input bit pbit,
                            input bit stop, input bit toggle);
    exp_t e;
    int   ones;
    ones = $countones(d);
    e.d  = d;
    e.fe = ~stop;
    e.pe = up && (((ones + int'(pbit)) % 2) != int'(odd_mode));
    e.pb = ones + (up ? int'(pbit) : 0);
    exp_q.push_back(e);
    use_parity = up;
    @(negedge clk);
    start_cyc = cyc;
    bit_out(1'b0, CPB);
    for (int i = 0; i < DB; i++) begin
      if (toggle && i == 3) use_parity = ~use_parity;
      bit_out(d[i], CPB);
    end
    if (up) bit_out(pbit, CPB);
    if (stop) begin
      bit_out(1'b1, CPB);
    end else begin
      // low through the mid-bit sample, high again before the FSM returns to idle
      bit_out(1'b0, 10);
      bit_out(1'b1, CPB - 10);
    end
  endtask

  task automatic check_all_zero(input string name);
    check(name, {17'd0, par_clear, par_bit, par_done, data_valid, frame_error,
                 parity_error, busy, data_out}, 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int pc, bz, pbn, dv;
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // 0xA5 with even parity bit 0, checker even
    odd_mode = 1'b0;
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 1'b0);
    check("a5_data", 32'(data_out), 32'h0A5);
    check("a5_fe", 32'(frame_error), 0);
    check("a5_pe", 32'(parity_error), 0);
    check("a5_latency", valid_cyc - start_cyc, 173);

    // Same frame, checker odd -> parity error
    odd_mode = 1'b1;
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 1'b0);
    check("a5odd_data", 32'(data_out), 32'h0A5);
    check("a5odd_pe", 32'(parity_error), 1);
    check("a5odd_fe", 32'(frame_error), 0);
    odd_mode = 1'b0;

    // No parity, use_parity toggled mid-frame
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b1);
    check("3c_data", 32'(data_out), 32'h03C);
    check("3c_pe", 32'(parity_error), 0);
    check("3c_latency", valid_cyc - start_cyc, 157);

    // Framing error, then clean frame
    send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ff_data", 32'(data_out), 32'h0FF);
    check("ff_fe", 32'(frame_error), 1);
    send_frame(8'h01, 1'b0, 1'b0, 1'b1, 1'b0);
    check("01_data", 32'(data_out), 32'h001);
    check("01_fe", 32'(frame_error), 0);

    // 5-cycle glitch in idle
    repeat (5) @(negedge clk);
    pc = 0; bz = 0; pbn = 0; dv = 0;
    for (int i = 0; i < 40; i++) begin
      rx = (i < 5) ? 1'b0 : 1'b1;
      @(negedge clk);
      pc += int'(par_clear); bz += int'(busy); pbn += int'(par_bit); dv += int'(data_valid);
    end
    check("glitch_par_clear", pc, 1);
    check("glitch_busy_cycles", bz, 8);
    check("glitch_par_bit", pbn, 0);
    check("glitch_valid", dv, 0);
    check("glitch_busy_end", 32'(busy), 0);

    // Reset during data bit 4
    use_parity = 1'b0;
    @(negedge clk);
    bit_out(1'b0, CPB);
    for (int i = 0; i < 4; i++) bit_out(i[0] ? 1'b1 : 1'b0, CPB);
    rx = 1'b1;
    repeat (8) @(negedge clk);
    #2 reset = 1'b1;
    #1 check_all_zero("async_reset");
    rx = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0);
    check("5a_data", 32'(data_out), 32'h05A);
    check("5a_fe", 32'(frame_error), 0);

    // Randomised frames
    for (int n = 0; n < 30; n++) begin
      odd_mode = 1'($urandom_range(0, 1));
      send_frame(8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 12)) @(negedge clk);
    end

    repeat (20) @(negedge clk);
    check("model_queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
